// File: rtl/mmio_periph_if.sv
// Data-memory side bus between the core and the MMIO peripheral block.
// Request signals come from the core; sel/read-data/read-hit return to it.
// No flow control: every access completes, reads one cycle later.
interface mmio_periph_if;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_i;
    logic        sel_o;
    logic [31:0] data_o;
    logic        rd_hit_o;

    modport master (
        output data_ce_i, data_we_i, data_addr_i, data_i,
        input  sel_o, data_o, rd_hit_o
    );

    modport slave (
        input  data_ce_i, data_we_i, data_addr_i, data_i,
        output sel_o, data_o, rd_hit_o
    );
endinterface

// File: rtl/mmio_periph.sv
// MMIO peripheral: 32-byte register window with an 8N1 UART transmitter and a 32-bit compare timer.
// Latency: writes take effect at the access edge; read data/rd_hit registered, valid one cycle later.
// Backpressure: none; every access is accepted, TXDATA writes while the UART is busy are dropped.
module mmio_periph #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          rst,
    mmio_periph_if.slave  bus,
    output logic          uart_tx,
    output logic          irq_o
);
    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          done;

    logic [31:0]   count;
    logic [31:0]   cmp;
    logic          enable;
    logic          pending;

    logic          hit;
    logic [2:0]    offset;
    logic          wr;
    logic          busy;
    logic [31:0]   rd_val;
    logic          unused_addr_lsb;

    assign hit             = bus.data_ce_i && (bus.data_addr_i[31:5] == BASE_ADDR[31:5]);
    assign offset          = bus.data_addr_i[4:2];
    assign wr              = hit && bus.data_we_i;
    assign busy            = (state != IDLE);
    assign bus.sel_o       = hit;
    assign irq_o           = pending;
    // Byte lanes are not supported; every access is a full word.
    assign unused_addr_lsb = ^bus.data_addr_i[1:0];

    // UART transmitter: start bit, 8 data bits LSB first, stop bit; tx driven straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
            done     <= 1'b0;
        end else begin
            // Clear first so a completing frame in the same cycle wins.
            if (wr && offset == 3'd1 && bus.data_i[1]) begin
                done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (wr && offset == 3'd0) begin
                        shreg    <= bus.data_i[7:0];
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        uart_tx  <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        uart_tx  <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Free-running timer with load override and sticky compare-match pending bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            cmp     <= '1;
            enable  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (wr && offset == 3'd2) begin
                count <= bus.data_i;
            end else if (enable) begin
                count <= count + 32'd1;
            end
            if (wr && offset == 3'd3) begin
                cmp <= bus.data_i;
            end
            if (wr && offset == 3'd4) begin
                enable <= bus.data_i[0];
                if (bus.data_i[1]) begin
                    pending <= 1'b0;
                end
            end
            // Match on the pre-increment value; set overrides a same-cycle clear.
            if (enable && count == cmp) begin
                pending <= 1'b1;
            end
        end
    end

    // Register read mux on the state as it stands before this cycle's updates.
    always_comb begin
        rd_val = '0;
        case (offset)
            3'd1:    rd_val = {30'd0, done, busy};
            3'd2:    rd_val = count;
            3'd3:    rd_val = cmp;
            3'd4:    rd_val = {30'd0, pending, enable};
            default: rd_val = '0;
        endcase
    end

    // Registered read return, lined up with the WB-stage sample of memory read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data_o   <= '0;
            bus.rd_hit_o <= 1'b0;
        end else if (hit && !bus.data_we_i) begin
            bus.data_o   <= rd_val;
            bus.rd_hit_o <= 1'b1;
        end else begin
            bus.data_o   <= '0;
            bus.rd_hit_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mmio_periph.sv
module tb_mmio_periph;
    localparam int          C    = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_tx;
    logic irq_o;

    mmio_periph_if bus ();

    mmio_periph #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .uart_tx (uart_tx),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: frame timing from the start edge, timer as plain arithmetic.
    int unsigned t;
    bit          m_started;
    int unsigned m_w;
    logic [7:0]  m_byte;
    bit          m_done;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    bit          m_en;
    bit          m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return m_started && ((t - m_w) < 10 * C);
    endfunction

    function automatic logic m_tx();
        int unsigned k;
        if (!m_busy()) return 1'b1;
        k = (t - m_w) / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    function automatic void model_reset();
        t = 0; m_started = 0; m_w = 0; m_byte = '0; m_done = 0;
        m_count = '0; m_cmp = '1; m_en = 0; m_pend = 0;
    endfunction

    // One bus cycle: drive, check sel, clock, update model, check registered outputs.
    task automatic cycle(input logic ce, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic o_sel, output logic o_hit, output logic [31:0] o_dat, output logic o_tx);
        logic        hit;
        logic [2:0]  off;
        logic [31:0] rv;
        bit          busy, ending, match, en_pre;
        bus.data_ce_i = ce; bus.data_we_i = we; bus.data_addr_i = addr; bus.data_i = wdata;
        #1;
        hit = ce && (addr[31:5] == BASE[31:5]);
        off = addr[4:2];
        chk("sel_o", bus.sel_o, hit);
        o_sel = bus.sel_o;
        busy = m_busy();
        case (off)
            3'd1:    rv = {30'd0, m_done, busy};
            3'd2:    rv = m_count;
            3'd3:    rv = m_cmp;
            3'd4:    rv = {30'd0, m_pend, m_en};
            default: rv = '0;
        endcase
        ending = busy && ((t + 1 - m_w) == 10 * C);
        match  = m_en && (m_count == m_cmp);
        en_pre = m_en;
        @(posedge clk);
        #1;
        if (hit && we && off == 3'd2) m_count = wdata;
        else if (en_pre)              m_count = m_count + 32'd1;
        if (hit && we) begin
            case (off)
                3'd0: if (!busy) begin m_started = 1; m_w = t + 1; m_byte = wdata[7:0]; end
                3'd1: if (wdata[1]) m_done = 0;
                3'd3: m_cmp = wdata;
                3'd4: begin m_en = wdata[0]; if (wdata[1]) m_pend = 0; end
                default: ;
            endcase
        end
        if (ending) m_done = 1;
        if (match)  m_pend = 1;
        t++;
        chk("rd_hit_o", bus.rd_hit_o, hit && !we);
        chk("data_o", bus.data_o, (hit && !we) ? rv : 32'd0);
        chk("uart_tx", uart_tx, m_tx());
        chk("irq_o", irq_o, m_pend);
        o_hit = bus.rd_hit_o; o_dat = bus.data_o; o_tx = uart_tx;
    endtask

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_sel;
        logic        exp_hit;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic        s, h, tx;
        logic [31:0] d;
        logic [9:0]  pat;

        vecs[0]  = '{1, 0, 32'h1000_0008, 32'h0,        1, 1, 32'h0};
        vecs[1]  = '{1, 0, 32'h1000_0020, 32'h0,        0, 0, 32'h0};
        vecs[2]  = '{1, 0, 32'h1000_000C, 32'h0,        1, 1, 32'hFFFF_FFFF};
        vecs[3]  = '{1, 0, 32'h1000_0010, 32'h0,        1, 1, 32'h0};
        vecs[4]  = '{1, 0, 32'h1000_0004, 32'h0,        1, 1, 32'h0};
        vecs[5]  = '{1, 1, 32'h1000_000E, 32'h1234,     1, 0, 32'h0};
        vecs[6]  = '{1, 0, 32'h1000_000D, 32'h0,        1, 1, 32'h1234};
        vecs[7]  = '{0, 0, 32'h1000_0008, 32'h0,        0, 0, 32'h0};
        vecs[8]  = '{1, 1, 32'h1000_0014, 32'hDEAD,     1, 0, 32'h0};
        vecs[9]  = '{1, 0, 32'h1000_0014, 32'h0,        1, 1, 32'h0};
        vecs[10] = '{1, 0, 32'h1000_001C, 32'h0,        1, 1, 32'h0};
        vecs[11] = '{1, 0, 32'h0FFF_FFFC, 32'h0,        0, 0, 32'h0};
        vecs[12] = '{1, 0, 32'h1000_0000, 32'h0,        1, 1, 32'h0};

        bus.data_ce_i = 0; bus.data_we_i = 0; bus.data_addr_i = '0; bus.data_i = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_rd_hit", bus.rd_hit_o, 1'b0);
        chk("rst_data_o", bus.data_o, 32'h0);

        // Decode and register map vectors.
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].wdata, s, h, d, tx);
            chk("vec_sel", s, vecs[i].exp_sel);
            chk("vec_hit", h, vecs[i].exp_hit);
            chk("vec_dat", d, vecs[i].exp_dat);
        end

        // UART frame 0x55 with STATUS reads.
        pat = 10'b1010101010;
        cycle(1, 1, BASE, 32'h55, s, h, d, tx);
        chk("frame55_bit", tx, pat[0]);
        for (int k = 1; k < 40; k++) begin
            if (k == 20) begin
                cycle(1, 0, BASE + 32'h4, 32'h0, s, h, d, tx);
                chk("status_mid", d, 32'h1);
            end else begin
                cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
            end
            chk("frame55_bit", tx, pat[k/C]);
        end
        cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
        chk("frame55_idle", tx, 1'b1);
        cycle(1, 0, BASE + 32'h4, 32'h0, s, h, d, tx);
        chk("status_done", d, 32'h2);
        cycle(1, 1, BASE + 32'h4, 32'h2, s, h, d, tx);
        cycle(1, 0, BASE + 32'h4, 32'h0, s, h, d, tx);
        chk("status_clr", d, 32'h0);

        // TXDATA write while busy is dropped.
        cycle(1, 1, BASE, 32'h55, s, h, d, tx);
        chk("busywr_bit", tx, pat[0]);
        for (int k = 1; k < 50; k++) begin
            if (k == 5) cycle(1, 1, BASE, 32'hFF, s, h, d, tx);
            else        cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
            chk("busywr_bit", tx, (k < 40) ? pat[k/C] : 1'b1);
        end
        cycle(1, 0, BASE + 32'h4, 32'h0, s, h, d, tx);
        chk("busywr_status", d, 32'h2);
        cycle(1, 1, BASE + 32'h4, 32'h2, s, h, d, tx);

        // Timer compare interrupt and hold when disabled.
        cycle(1, 1, BASE + 32'hC, 32'd10, s, h, d, tx);
        cycle(1, 1, BASE + 32'h8, 32'd0, s, h, d, tx);
        cycle(1, 1, BASE + 32'h10, 32'h1, s, h, d, tx);
        chk("irq_rise", irq_o, 1'b0);
        for (int j = 1; j <= 11; j++) begin
            cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
            chk("irq_rise", irq_o, (j >= 11) ? 1'b1 : 1'b0);
        end
        cycle(1, 1, BASE + 32'h10, 32'h2, s, h, d, tx);
        chk("irq_clr", irq_o, 1'b0);
        cycle(1, 0, BASE + 32'h8, 32'h0, s, h, d, tx);
        chk("count_hold1", d, 32'd12);
        repeat (3) cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
        cycle(1, 0, BASE + 32'h8, 32'h0, s, h, d, tx);
        chk("count_hold2", d, 32'd12);

        // Wrap and load override while running.
        cycle(1, 1, BASE + 32'h10, 32'h1, s, h, d, tx);
        cycle(1, 1, BASE + 32'h8, 32'hFFFF_FFFE, s, h, d, tx);
        cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
        cycle(1, 0, BASE + 32'h8, 32'h0, s, h, d, tx);
        chk("wrap0", d, 32'hFFFF_FFFF);
        cycle(1, 0, BASE + 32'h8, 32'h0, s, h, d, tx);
        chk("wrap1", d, 32'h0);
        cycle(1, 0, BASE + 32'h8, 32'h0, s, h, d, tx);
        chk("wrap2", d, 32'h1);
        cycle(1, 1, BASE + 32'h8, 32'h100, s, h, d, tx);
        repeat (3) cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
        cycle(1, 0, BASE + 32'h8, 32'h0, s, h, d, tx);
        chk("override", d, 32'h103);

        // Asynchronous reset in the middle of a frame with the interrupt pending.
        cycle(1, 1, BASE + 32'hC, 32'h200, s, h, d, tx);
        cycle(1, 1, BASE + 32'h8, 32'h200, s, h, d, tx);
        cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
        chk("pre_rst_irq", irq_o, 1'b1);
        cycle(1, 1, BASE, 32'h00, s, h, d, tx);
        repeat (10) cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
        cycle(1, 0, BASE + 32'hC, 32'h0, s, h, d, tx);
        chk("pre_rst_tx", tx, 1'b0);
        chk("pre_rst_dat", d, 32'h200);
        #2 rst = 1'b0;
        #1;
        chk("arst_tx", uart_tx, 1'b1);
        chk("arst_irq", irq_o, 1'b0);
        chk("arst_hit", bus.rd_hit_o, 1'b0);
        chk("arst_dat", bus.data_o, 32'h0);
        model_reset();
        bus.data_ce_i = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        cycle(1, 0, BASE + 32'h4, 32'h0, s, h, d, tx);
        chk("post_rst_status", d, 32'h0);
        cycle(1, 0, BASE + 32'hC, 32'h0, s, h, d, tx);
        chk("post_rst_cmp", d, 32'hFFFF_FFFF);
        pat = {1'b1, 8'hA5, 1'b0};
        cycle(1, 1, BASE, 32'hA5, s, h, d, tx);
        chk("frameA5_bit", tx, pat[0]);
        for (int k = 1; k < 42; k++) begin
            cycle(0, 0, 32'h0, 32'h0, s, h, d, tx);
            chk("frameA5_bit", tx, (k < 40) ? pat[k/C] : 1'b1);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            logic        ce, we;
            logic [2:0]  off;
            logic [31:0] a, w;
            ce  = ($urandom_range(0, 3) == 0);
            we  = 1'($urandom_range(0, 1));
            off = 3'($urandom_range(0, 7));
            w   = $urandom();
            case (off)
                3'd2:    if ($urandom_range(0, 1) == 1) w = 32'($urandom_range(0, 40));
                3'd3:    w = m_count + 32'($urandom_range(0, 30));
                default: ;
            endcase
            a = BASE | {27'd0, off, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a = a ^ (32'h1 << $urandom_range(5, 31));
            cycle(ce, we, a, w, s, h, d, tx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_periph.md
Name: mmio_periph

Overview:
- Memory-mapped peripheral block on the core's data-memory port, alongside the data RAM.
- Decodes accesses inside a 32-byte window and implements a UART transmitter (8N1) and a 32-bit timer with compare interrupt.
- Read data is registered, so it arrives in the cycle the WB stage samples data memory read data: one cycle after the MEM-stage access.
- Top level uses sel_o to steer writes and rd_hit_o to mux read data between RAM and this block.

Parameters:
BASE_ADDR, 32'h1000_0000, window base; must be 32-byte aligned
CLKS_PER_BIT, 868, clock cycles per UART bit; must be at least 2

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
data_ce_i  input  1  data memory enable from core
data_we_i  input  1  1 = write, 0 = read
data_addr_i  input  32  byte address from core
data_i  input  32  write data from core
sel_o  output  1  combinational: data_ce_i and address inside window
data_o  output  32  registered read data
rd_hit_o  output  1  registered: data_o is valid this cycle
uart_tx  output  1  serial output, idle high
irq_o  output  1  timer interrupt, level, equals pending bit

Behaviour:
- Decode and access rules:
  - hit = data_ce_i & (data_addr_i[31:5] == BASE_ADDR[31:5]).
  - Offset = data_addr_i[4:2]; data_addr_i[1:0] is ignored. All accesses are full words.
  - Register map by byte offset:
    - 0x00 TXDATA: write starts a frame with data_i[7:0] if the UART is idle; reads 0.
    - 0x04 STATUS: bit0 busy, bit1 done (sticky, set at end of stop bit). Writing 1 to bit1 clears done. Other bits read 0.
    - 0x08 COUNT: R/W timer value.
    - 0x0C CMP: R/W compare value.
    - 0x10 CTRL: bit0 enable (R/W), bit1 pending (sticky; writing 1 clears it).
    - 0x14 to 0x1C: read 0, writes ignored.
- Read path:
  - On a hit read (we=0), data_o <= selected register value as of that edge (before that cycle's updates) and rd_hit_o <= 1.
  - Otherwise data_o <= 0 and rd_hit_o <= 0.
  - Read latency is exactly 1 cycle. Back-to-back reads are supported every cycle.
- Writes take effect at the clock edge of the hit cycle.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1, busy=0. A TXDATA write latches the byte, clears the bit counter and moves to START at that edge.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE with done set at the same edge.
  - busy=1 in START, DATA and STOP. A full frame is 10*CLKS_PER_BIT cycles.
  - uart_tx is driven from a flop (glitch-free).
  - A TXDATA write while busy is ignored: byte and frame are unaffected.
  - A done W1C in the same cycle that done is being set: set wins.
- Timer:
  - When enable=1, COUNT increments by 1 each cycle and wraps 0xFFFF_FFFF to 0.
  - A COUNT write in the same cycle overrides the increment: the written value is loaded.
  - When enable=1 and COUNT==CMP, using the pre-increment value, pending is set at that edge. irq_o follows pending.
  - Pending set and W1C in the same cycle: set wins.
  - When enable=0, COUNT holds and no compare match is taken.
- Reset (rst=0, asynchronous, any time including mid-frame):
  - UART goes to IDLE, uart_tx=1, busy=0, done=0.
  - COUNT=0, CMP=0xFFFF_FFFF, enable=0, pending=0.
  - data_o=0, rd_hit_o=0, irq_o=0.
  - A frame in progress is abandoned, with no partial stop bit.
- sel_o is purely combinational and has no reset dependency.

Test Plan:
- Decode: ce=1, we=0, addr=0x1000_0008 after reset -> sel_o=1 same cycle; next cycle rd_hit_o=1, data_o=0. addr=0x1000_0020 -> sel_o=0 and rd_hit_o=0 next cycle.
- UART frame (CLKS_PER_BIT=4): write 0x55 to 0x00 -> uart_tx reads 0, then 1,0,1,0,1,0,1,0, then 1. Each bit lasts 4 cycles, 40 cycles total. STATUS read mid-frame = 0x1; after the frame = 0x2; after writing 0x2 to STATUS, it reads 0x0.
- Write while busy: write 0x55, then write 0xFF 5 cycles later -> the frame still carries 0x55 and no second frame starts.
- Timer compare: CMP=10, COUNT=0, CTRL=1 -> irq_o rises 11 cycles after the CTRL write. Writing 0x2 to CTRL clears it. With CTRL=0, COUNT holds its value.
- Wrap and override: COUNT=0xFFFF_FFFE with enable=1 -> reads advance 0xFFFF_FFFF, then 0, then 1. Writing 0x100 while enabled -> the next read shows 0x100 plus elapsed cycles, with no lost or extra increment.
- Reset mid-frame: rst=0 during DATA -> uart_tx=1, STATUS=0, irq_o=0 immediately (asynchronous). After rst=1, a new TXDATA write starts a clean frame.
